// File: rtl/aes_pkg.sv
// Shared helpers for the AES ShiftRows datapath: row offsets, byte placement,
// legal block widths and the elastic-buffer state encoding.
package aes_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Rijndael allows 4, 6 or 8 state columns in this datapath.
    function automatic bit nb_legal(input int unsigned nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Row rotation amount; the 8-column block skips offset 2.
    function automatic int unsigned row_offset(input int unsigned nb, input int unsigned row);
        if (nb == 8 && row >= 2)
            return row + 1;
        return row;
    endfunction

    // MSB position of byte k = 4*col + row; byte 0 sits at the top of the vector.
    function automatic int unsigned byte_msb(input int unsigned nb, input int unsigned col,
                                             input int unsigned row);
        return 32 * nb - 1 - 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module aes_shift_rows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] data,
    input  logic             inv,
    output logic [32*NB-1:0] permuted
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned OFF     = row_offset(NB, r);
            localparam int unsigned SRC_FWD = (c + OFF) % NB;
            localparam int unsigned SRC_INV = (c + NB - OFF) % NB;
            localparam int unsigned DST_MSB = byte_msb(NB, c, r);
            localparam int unsigned FWD_MSB = byte_msb(NB, SRC_FWD, r);
            localparam int unsigned INV_MSB = byte_msb(NB, SRC_INV, r);

            assign permuted[DST_MSB -: 8] = inv ? data[INV_MSB -: 8] : data[FWD_MSB -: 8];
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Handshaked ShiftRows / InvShiftRows stage: permutes on entry, then holds up to
// two blocks (head register + skid entry) with their direction bit and tag.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic               out_inv,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy
);

    localparam int unsigned W = 32 * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    typedef struct packed {
        logic [W-1:0]     data;
        logic             inv;
        logic [TAG_W-1:0] tag;
    } entry_t;

    buf_state_t   state_q, state_d;
    entry_t       head_q, head_d;
    entry_t       skid_q, skid_d;
    entry_t       in_entry;
    logic [W-1:0] data_gated;
    logic [W-1:0] data_perm;
    logic         in_xfer;
    logic         out_xfer;

    // Gate idle input so unknown data never reaches the permutation or buffer.
    assign data_gated = in_valid ? in_data : '0;

    aes_shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .data     (data_gated),
        .inv      (in_inv),
        .permuted (data_perm)
    );

    always_comb begin
        in_entry      = '0;
        in_entry.data = data_perm;
        in_entry.inv  = in_inv;
        in_entry.tag  = in_tag;
    end

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            BUF_ONE:  occupancy = 2'd1;
            BUF_FULL: occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (in_xfer) begin
                    head_d  = in_entry;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        skid_d  = in_entry;
                        state_d = BUF_FULL;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    2'b11: head_d = in_entry;
                    default: ;
                endcase
            end
            BUF_FULL: begin
                if (out_xfer) begin
                    head_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_data = head_q.data;
    assign out_inv  = head_q.inv;
    assign out_tag  = head_q.tag;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: queue-based reference model plus directed
// vectors for NB=4 and NB=8.
module tb_aes_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         reset;

    logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [127:0] in_data, out_data;
    logic [3:0]   in_tag, out_tag;
    logic [1:0]   occupancy;

    logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
    logic [255:0] in_data8, out_data8;
    logic [3:0]   in_tag8, out_tag8;
    logic [1:0]   occupancy8;

    int tests = 0;
    int fails = 0;
    int n_out = 0;

    typedef struct {
        logic [127:0] data;
        logic         inv;
        logic [3:0]   tag;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inv(out_inv), .out_tag(out_tag), .occupancy(occupancy)
    );

    aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_inv(in_inv8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_inv(out_inv8), .out_tag(out_tag8), .occupancy(occupancy8)
    );

    // State as a grid st[row][col]; byte k = 4*col+row counted from the top of the vector.
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input bit inv);
        logic [7:0]   st [4][8];
        logic [255:0] res;
        int           off, src;
        res = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                off = (nb == 8 && r >= 2) ? r + 1 : r;
                src = inv ? (c - off + nb) % nb : (c + off) % nb;
                res[32*nb-1-8*(4*c+r) -: 8] = st[r][src];
            end
        return res;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare process: outputs checked against the model queue, then upcoming edge applied to it.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
        end else begin
            check("occupancy", {254'd0, occupancy}, q.size());
            check("in_ready", {255'd0, in_ready}, {255'd0, q.size() != 2});
            check("out_valid", {255'd0, out_valid}, {255'd0, q.size() != 0});
            if (out_valid && q.size() != 0) begin
                check("out_data", {128'd0, out_data}, {128'd0, q[0].data});
                check("out_inv", {255'd0, out_inv}, {255'd0, q[0].inv});
                check("out_tag", {252'd0, out_tag}, {252'd0, q[0].tag});
            end
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                e.data = ref_shift(4, {128'd0, in_data}, in_inv)[127:0];
                e.inv  = in_inv;
                e.tag  = in_tag;
                q.push_back(e);
            end
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && occupancy != 2'd0; i++)
            cyc();
        check("drain_empty", {254'd0, occupancy}, 256'd0);
    endtask

    logic [255:0] v8, r8;
    logic [255:0] tmp;
    int           base;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_tag = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_inv8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_occ", {254'd0, occupancy}, 256'd0);
        check("rst_in_ready", {255'd0, in_ready}, 256'd1);
        check("rst_out_valid", {255'd0, out_valid}, 256'd0);

        // Model pinned to the FIPS-197 ShiftRows example and the NB=8 column.
        tmp = ref_shift(4, {128'd0, 128'hd42711aee0bf98f1b8b45de51e415230}, 1'b0);
        check("model_fwd4", tmp, {128'd0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});

        in_valid = 1'b1; in_data = 128'hd42711aee0bf98f1b8b45de51e415230; in_inv = 1'b0; in_tag = 4'h5;
        cyc();
        in_valid = 1'b0;
        check("vec_fwd4", {128'd0, out_data}, {128'd0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        check("vec_fwd4_inv", {255'd0, out_inv}, 256'd0);
        check("vec_fwd4_valid", {255'd0, out_valid}, 256'd1);
        cyc();

        in_valid = 1'b1; in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5; in_inv = 1'b1; in_tag = 4'h9;
        cyc();
        in_valid = 1'b0;
        check("vec_inv4", {128'd0, out_data}, {128'd0, 128'hd42711aee0bf98f1b8b45de51e415230});
        check("vec_inv4_inv", {255'd0, out_inv}, 256'd1);
        check("vec_inv4_tag", {252'd0, out_tag}, 256'd9);
        drain();

        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = i[0];
            in_tag   = i[3:0];
            cyc();
        end
        drain();

        for (int k = 0; k < 32; k++)
            v8[255-8*k -: 8] = k[7:0];
        in_valid8 = 1'b1; in_data8 = v8; in_inv8 = 1'b0; in_tag8 = 4'h3;
        cyc();
        in_valid8 = 1'b0;
        r8 = out_data8;
        check("nb8_col0", {224'd0, r8[255 -: 32]}, {224'd0, 32'h00050e13});
        check("nb8_fwd", r8, ref_shift(8, v8, 1'b0));
        check("nb8_valid", {255'd0, out_valid8}, 256'd1);
        cyc();
        in_valid8 = 1'b1; in_data8 = r8; in_inv8 = 1'b1;
        cyc();
        in_valid8 = 1'b0;
        check("nb8_roundtrip", out_data8, v8);
        check("nb8_out_inv", {255'd0, out_inv8}, 256'd1);
        cyc();

        out_ready = 1'b0;
        in_valid = 1'b1; in_inv = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom}; in_tag = 4'd1;
        cyc();
        in_data = {$urandom, $urandom, $urandom, $urandom}; in_tag = 4'd2;
        cyc();
        check("bp_in_ready", {255'd0, in_ready}, 256'd0);
        check("bp_occ_full", {254'd0, occupancy}, 256'd2);
        in_data = {$urandom, $urandom, $urandom, $urandom}; in_tag = 4'd3;
        cyc();
        check("bp_hold_tag", {252'd0, out_tag}, 256'd1);
        check("bp_hold_occ", {254'd0, occupancy}, 256'd2);
        out_ready = 1'b1;
        cyc();
        check("bp_tag2", {252'd0, out_tag}, 256'd2);
        check("bp_occ1", {254'd0, occupancy}, 256'd1);
        cyc();
        check("bp_tag3", {252'd0, out_tag}, 256'd3);
        in_valid = 1'b0;
        drain();

        base = n_out;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = $urandom_range(0, 1);
            in_tag   = 4'($urandom);
            cyc();
            check("stream_occ", {254'd0, occupancy}, 256'd1);
        end
        in_valid = 1'b0;
        cyc();
        check("stream_count", n_out - base, 256'd20);
        drain();

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_inv    = $urandom_range(0, 1);
            in_tag    = 4'($urandom);
            cyc();
        end
        drain();

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_inv = 1'b1; in_tag = 4'hA;
        cyc();
        in_tag = 4'hB;
        cyc();
        check("prerst_occ", {254'd0, occupancy}, 256'd2);
        reset = 1'b1;
        in_tag = 4'hC;
        out_ready = 1'b1;
        cyc();
        reset = 1'b0;
        in_valid = 1'b0;
        check("rst2_out_valid", {255'd0, out_valid}, 256'd0);
        check("rst2_occ", {254'd0, occupancy}, 256'd0);
        check("rst2_in_ready", {255'd0, in_ready}, 256'd1);
        check("rst2_out_data", {128'd0, out_data}, 256'd0);
        check("rst2_out_tag", {252'd0, out_tag}, 256'd0);
        check("rst2_out_inv", {255'd0, out_inv}, 256'd0);
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_shift_rows_pipe.md
# aes_shift_rows_pipe

Parametrised, handshaked ShiftRows / InvShiftRows stage for the AES datapath. Supports Rijndael block widths of 4, 6 or 8 columns and a per-block direction bit, so one instance serves both encrypt and decrypt rounds. A two-entry elastic buffer with valid/ready on both sides lets it sit between SubBytes and MixColumns without stalling or dropping blocks under back-pressure.

## Interface
- NB, 4: state columns; legal values 4, 6, 8 (block width 32*NB bits); any other value is an elaboration error
- TAG_W, 4: width of the user tag carried alongside each block
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input block present
- in_ready  out  1  stage can accept a block this cycle
- in_data  in  32*NB  input state, byte k = bits [32*NB-1-8k -: 8], column-major (k = 4*col + row)
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows
- in_tag  in  TAG_W  user tag, passed through unchanged
- out_valid  out  1  output block present
- out_ready  in  1  downstream accepts
- out_data  out  32*NB  permuted state, same byte layout
- out_inv  out  1  direction bit of the output block
- out_tag  out  TAG_W  tag of the output block
- occupancy  out  2  blocks held (0..2)

## Operation
- Row offsets: NB=4 or 6 -> {0,1,2,3}; NB=8 -> {0,1,3,4}.
- Forward: out[r][c] = in[r][(c + off_r) mod NB]. Inverse: out[r][c] = in[r][(c - off_r) mod NB]. Row 0 always unchanged.
- Permutation is applied on the input side; buffer entries store permuted data with their inv bit and tag.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Buffer: 2-entry FIFO (head = output register, skid = second entry). States EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - EMPTY: in xfer -> ONE.
  - ONE: in xfer only -> FULL; out xfer only -> EMPTY; both simultaneously -> ONE, new block becomes head.
  - FULL: out xfer -> ONE, skid moves to head; no input accepted.
- Strict FIFO order; no block dropped or duplicated; every direction bit and tag stays attached to its own block.
- in_ready = (occupancy != 2), driven from registers only; no combinational path from out_ready to in_ready.
- out_valid = (occupancy != 0). out_data/out_inv/out_tag stable while out_valid & !out_ready.
- in_data is ignored when in_valid is low; X on in_data in that case must not propagate.

## Timing
- Latency: block accepted in cycle N is presented on out_* in cycle N+1 (buffer empty).
- Throughput: one block per cycle when out_ready held high.
- Reset (synchronous, active-high): occupancy=0, out_valid=0, in_ready=1 from the first cycle after the reset edge; out_data, out_inv, out_tag cleared to 0. In-flight blocks are discarded; input offered during the reset cycle is not accepted.
- Reset wins over any simultaneous transfer.
- FULL with out_ready high: in_ready still 0 that cycle (registered); input accepted again the next cycle.

## Structure
- Package aes_pkg: function returning row offset for (NB, row); byte-index helper (col, row) -> bit slice; legal-NB check constant.
- Sub-module aes_shift_rows_perm: purely combinational, parameter NB, inputs data and inv, output permuted data; instanced once on the input side. Buffer control stays in the top.

## Test plan
- NB=4, inv=0, in_data d42711aee0bf98f1b8b45de51e415230 -> out_data d4bf5d30e0b452aeb84111f11e2798e5 one cycle later, out_inv=0.
- NB=4, inv=1, in_data d4bf5d30e0b452aeb84111f11e2798e5 -> out_data d42711aee0bf98f1b8b45de51e415230; alternating inv per back-to-back block, tags 0..15 -> each output matches its own inv and tag.
- NB=8, inv=0, in_data bytes 00..1f ascending -> first output column 00 05 0e 13; inverse of that result returns 00..1f.
- Back-pressure: out_ready=0, offer 3 blocks tags 1,2,3 -> tags 1,2 accepted, in_ready=0 after second, occupancy=2; out_ready=1 -> outputs 1,2,3 in order, no loss.
- Streaming: in_valid and out_ready high 20 cycles -> 20 outputs, one per cycle, occupancy stays 1.
- Reset with occupancy=2 -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0; no pre-reset block emerges.
